// File: rtl/dmem_miss_handler.sv
// Data-memory miss handler: accepts one aligned load/store, retries on miss with a
// fixed back-off, and faults on illegal requests or too many misses. Optional MissCount via DMEM_MISS_COUNT_EN.
module dmem_miss_handler #(
  parameter int unsigned RETRY_WAIT = 4,
  parameter int unsigned MAX_RETRY  = 7
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        reqRead_i,
  input  logic        reqWrite_i,
  input  logic [31:0] reqAddress_i,
  input  logic [31:0] reqWriteData_i,
  input  logic [31:0] ReadData_i,
  input  logic        DMemError_i,
  output logic        memRead_o,
  output logic        memWrite_o,
  output logic [31:0] Address_o,
  output logic [31:0] WriteData_o,
  output logic        Stall_o,
  output logic [31:0] LoadData_o,
  output logic        LoadValid_o,
`ifdef DMEM_MISS_COUNT_EN
  output logic [15:0] MissCount_o,
`endif
  output logic        AccessFault_o
);

  // state  | meaning
  // IDLE   | waiting for a pipeline request
  // ACCESS | strobe issued this cycle, DMemError sampled at its end
  // WAIT   | back-off between a miss and its retry
  // FAULT  | one-cycle AccessFault pulse
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, FAULT} state_e;

  localparam logic [3:0] WaitLoad = 4'(RETRY_WAIT - 1);
  localparam logic [3:0] MaxRetry = 4'(MAX_RETRY);

  state_e      state_q;
  logic        is_read_q;
  logic [3:0]  retry_q;
  logic [3:0]  retry_d;
  logic [3:0]  wait_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] load_data_q;
  logic        load_valid_q;
  logic        fault_q;
  logic        req_any;
  logic        req_ok;

  assign req_any = reqRead_i | reqWrite_i;
  assign req_ok  = (reqRead_i ^ reqWrite_i) && (reqAddress_i[1:0] == 2'b00);
  assign retry_d = retry_q + 4'd1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      is_read_q    <= 1'b0;
      retry_q      <= 4'd0;
      wait_q       <= 4'd0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      load_data_q  <= 32'd0;
      load_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      load_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_ok) begin
            addr_q      <= reqAddress_i;
            wdata_q     <= reqWriteData_i;
            is_read_q   <= reqRead_i;
            retry_q     <= 4'd0;
            mem_read_q  <= reqRead_i;
            mem_write_q <= reqWrite_i;
            state_q     <= ACCESS;
          end else if (req_any) begin
            fault_q <= 1'b1;
            state_q <= FAULT;
          end
        end
        ACCESS: begin
          if (!DMemError_i) begin
            if (is_read_q) begin
              load_data_q  <= ReadData_i;
              load_valid_q <= 1'b1;
            end
            state_q <= IDLE;
          end else begin
            retry_q <= retry_d;
            if (retry_d == MaxRetry) begin
              fault_q <= 1'b1;
              state_q <= FAULT;
            end else begin
              wait_q  <= WaitLoad;
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          // Strobe is registered, so it is raised on the edge that enters ACCESS.
          if (wait_q == 4'd0) begin
            mem_read_q  <= is_read_q;
            mem_write_q <= ~is_read_q;
            state_q     <= ACCESS;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        FAULT: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DMEM_MISS_COUNT_EN
  logic [15:0] miss_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      miss_cnt_q <= 16'd0;
    end else if (state_q == ACCESS && DMemError_i && miss_cnt_q != 16'hFFFF) begin
      miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign MissCount_o = miss_cnt_q;
`endif

  assign memRead_o     = mem_read_q;
  assign memWrite_o    = mem_write_q;
  assign Address_o     = addr_q;
  assign WriteData_o   = wdata_q;
  assign LoadData_o    = load_data_q;
  assign LoadValid_o   = load_valid_q;
  assign AccessFault_o = fault_q;
  assign Stall_o       = (state_q != IDLE) || req_any;

endmodule

// File: doc/dmem_miss_handler.md
DMEM_MISS_HANDLER -- requirements
Module: dmem_miss_handler

Interface
REQ-001 The block SHALL have parameter RETRY_WAIT, default 4, meaning idle cycles inserted between a missed access and its retry (legal 1..15).
REQ-002 The block SHALL have parameter MAX_RETRY, default 7, meaning missed attempts tolerated before fault (legal 1..15).
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Rst  input  1  asynchronous, active-high reset.
REQ-005 reqRead  input  1  pipeline MEM-stage load request.
REQ-006 reqWrite  input  1  pipeline MEM-stage store request.
REQ-007 reqAddress  input  32  byte address of the request.
REQ-008 reqWriteData  input  32  store data.
REQ-009 ReadData  input  32  data returned by data memory.
REQ-010 DMemError  input  1  data-memory miss flag, valid in the same cycle as the access.
REQ-011 memRead  output  1  read strobe to data memory.
REQ-012 memWrite  output  1  write strobe to data memory.
REQ-013 Address  output  32  registered address to data memory.
REQ-014 WriteData  output  32  registered store data to data memory.
REQ-015 Stall  output  1  freezes the pipeline while a request is outstanding.
REQ-016 LoadData  output  32  captured load result.
REQ-017 LoadValid  output  1  one-cycle pulse when LoadData is updated.
REQ-018 AccessFault  output  1  one-cycle pulse on rejected or abandoned request.

Function
REQ-019 The FSM SHALL use states IDLE, ACCESS, WAIT and FAULT.
REQ-020 In IDLE, a request with exactly one of reqRead/reqWrite set and reqAddress[1:0]==0 SHALL be accepted: latch address, data and kind, clear the retry count, next state ACCESS.
REQ-021 In IDLE, reqRead&&reqWrite or a misaligned address SHALL go to FAULT with no memory strobe.
REQ-022 Stall SHALL be 1 whenever state != IDLE, and combinationally 1 in IDLE while reqRead||reqWrite is high.
REQ-023 In ACCESS, memRead or memWrite (per latched kind) SHALL be 1 for exactly that cycle; both SHALL be 0 in all other states.
REQ-024 In ACCESS with DMemError==0: a read SHALL register ReadData into LoadData and pulse LoadValid next cycle; both kinds SHALL return to IDLE.
REQ-025 In ACCESS with DMemError==1, the retry count SHALL increment; if the new count equals MAX_RETRY, next state FAULT, else WAIT.
REQ-026 WAIT SHALL last exactly RETRY_WAIT cycles, then return to ACCESS with the same address/data.
REQ-027 FAULT SHALL last one cycle with AccessFault=1, then return to IDLE; LoadData SHALL be unchanged.
REQ-028 Hit-read latency: request in cycle 0, strobe in cycle 1, LoadValid=1 and Stall=0 in cycle 2.
REQ-029 Each miss SHALL add RETRY_WAIT+1 cycles to the latency.
REQ-030 Requests arriving while state != IDLE SHALL be ignored (pipeline is stalled).

Reset
REQ-031 Rst SHALL force state IDLE, retry count 0, memRead=0, memWrite=0, Address=0, WriteData=0, LoadData=0, LoadValid=0, AccessFault=0, immediately and asynchronously.
REQ-032 Reset asserted mid-access or mid-WAIT SHALL abandon the request with no LoadValid, AccessFault or further strobe after release.

Configuration
REQ-033 With DMEM_MISS_COUNT_EN defined, the block SHALL add output MissCount (16 bits, reset 0), incremented on every ACCESS cycle with DMemError==1 and saturating at 16'hFFFF.
REQ-034 Without DMEM_MISS_COUNT_EN, MissCount and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-035 Hit read: reqRead, reqAddress=0x10, ReadData=0x12345678, DMemError=0 -> memRead in cycle 1, LoadData=0x12345678 with LoadValid in cycle 2, Stall high for cycles 0-1 only.
REQ-036 One miss then hit (defaults): write to 0x8, DMemError=1 on first strobe -> second memWrite exactly 5 cycles after the first, Address=0x8 both times, no fault.
REQ-037 Persistent miss: DMemError held 1 -> exactly 7 strobes, then AccessFault one-cycle pulse, Stall drops, LoadValid never asserted.
REQ-038 Illegal requests: reqRead&&reqWrite, and reqRead at 0x6 -> AccessFault pulse in cycle 1, no memRead/memWrite.
REQ-039 Reset mid-WAIT: assert Rst during WAIT -> all outputs 0 immediately; after release no strobe until a new request.
REQ-040 With DMEM_MISS_COUNT_EN: three single-miss reads -> MissCount=3; force 65536 misses -> MissCount holds 16'hFFFF.
